// File: rtl/seg_scan_driver_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
//
// Shared constants for the multiplexed 7-segment scan driver:
//   - SEG_W          : width of one segment pattern {a,b,c,d,e,f,g,dp}
//   - GLYPH_*        : named 4-bit glyph codes used by the mode/song controller
//   - GLYPH_BITMAP   : 16-entry a..g bitmap, one entry per glyph code
//   - blink_phase_t  : visible / dark half of the blink cycle
//   - glyph_pattern(): code + dp -> full 8-bit segment pattern
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam int SEG_W  = 8;
    localparam int CODE_W = 4;

    // Numeric glyphs
    localparam logic [CODE_W-1:0] GLYPH_0 = 4'd0;
    localparam logic [CODE_W-1:0] GLYPH_1 = 4'd1;
    localparam logic [CODE_W-1:0] GLYPH_2 = 4'd2;
    localparam logic [CODE_W-1:0] GLYPH_3 = 4'd3;
    localparam logic [CODE_W-1:0] GLYPH_8 = 4'd8;
    localparam logic [CODE_W-1:0] GLYPH_9 = 4'd9;

    // Letter glyphs reused by the mode/song controller for status words
    localparam logic [CODE_W-1:0] GLYPH_R = 4'd4;
    localparam logic [CODE_W-1:0] GLYPH_S = 4'd5;
    localparam logic [CODE_W-1:0] GLYPH_H = 4'd6;
    localparam logic [CODE_W-1:0] GLYPH_L = 4'd7;
    localparam logic [CODE_W-1:0] GLYPH_A = 4'd10;
    localparam logic [CODE_W-1:0] GLYPH_B = 4'd11;
    localparam logic [CODE_W-1:0] GLYPH_C = 4'd12;
    localparam logic [CODE_W-1:0] GLYPH_D = 4'd13;
    localparam logic [CODE_W-1:0] GLYPH_E = 4'd14;
    localparam logic [CODE_W-1:0] GLYPH_F = 4'd15;

    // Segment bitmaps, a..g with a in the MSB. Listed from code 15 down to
    // code 0 so that GLYPH_BITMAP[code] picks the entry for that code.
    localparam logic [15:0][6:0] GLYPH_BITMAP = {
        7'b1000111,   // F
        7'b1001111,   // E
        7'b0111101,   // d
        7'b1001110,   // C
        7'b0011111,   // b
        7'b1110111,   // A
        7'b1110011,   // 9
        7'b1111111,   // 8
        7'b0001110,   // L
        7'b0110111,   // H
        7'b1011011,   // S
        7'b0000101,   // r
        7'b1111001,   // 3
        7'b1101101,   // 2
        7'b0110000,   // 1
        7'b1111110    // 0
    };

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_phase_t;

    // Every 4-bit code has a bitmap, so no fallback path is needed here;
    // hiding a digit is the job of the blank/blink masks upstream.
    function automatic logic [SEG_W-1:0] glyph_pattern(
        input logic [CODE_W-1:0] code,
        input logic              dp
    );
        return {GLYPH_BITMAP[code], dp};
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// ----------------------------------------------------------------------------
// seg_scan_if
//
// Bundle between the mode/song controller (master) and the scan driver
// (slave).
//   codes_in   : 4 bits per digit, digit k in [4k+3:4k]
//   blank_in   : per-digit force-dark mask
//   blink_in   : per-digit dark-during-blink-off mask
//   dp_in      : per-digit decimal point
//   load       : one-cycle strobe capturing all *_in into staging
//   seg_out    : {a,b,c,d,e,f,g,dp}, active-high
//   dig_sel    : one-hot digit enable, active-high
//   frame_done : one-cycle pulse at the end of the last digit slot
// ----------------------------------------------------------------------------
interface seg_scan_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8
);

    logic [CODE_W*NUM_DIGITS-1:0] codes_in;
    logic [NUM_DIGITS-1:0]        blank_in;
    logic [NUM_DIGITS-1:0]        blink_in;
    logic [NUM_DIGITS-1:0]        dp_in;
    logic                         load;
    logic [SEG_W-1:0]             seg_out;
    logic [NUM_DIGITS-1:0]        dig_sel;
    logic                         frame_done;

    modport master (
        output codes_in,
        output blank_in,
        output blink_in,
        output dp_in,
        output load,
        input  seg_out,
        input  dig_sel,
        input  frame_done
    );

    modport slave (
        input  codes_in,
        input  blank_in,
        input  blink_in,
        input  dp_in,
        input  load,
        output seg_out,
        output dig_sel,
        output frame_done
    );

endinterface

// File: rtl/seg_scan_driver_glyph_decode.sv
// ----------------------------------------------------------------------------
// seg_glyph_decode
//
// Purely combinational glyph decoder shared by all digits: the scan driver
// muxes the active entry of the digit being shown and feeds it through here.
//   code    : 4-bit glyph code
//   dp      : decimal point for this digit
//   pattern : {a,b,c,d,e,f,g,dp}, active-high
// ----------------------------------------------------------------------------
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              dp,
    output logic [SEG_W-1:0]  pattern
);

    assign pattern = glyph_pattern(code, dp);

endmodule

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver
//
// Drives an N-digit multiplexed 7-segment bank. Each digit owns a slot of
// SCAN_DIV cycles; the first DEAD_CYCLES of every slot keep all digits off so
// the previous digit's pattern cannot ghost onto the next one. New display
// data is double buffered: load captures into staging, and staging is only
// committed to the active set at a frame boundary, so a frame never shows a
// mix of old and new data.
//
// Ports
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : seg_scan_if.slave (inputs codes/blank/blink/dp/load,
//         outputs seg_out/dig_sel/frame_done)
// ----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int DEAD_CYCLES  = 200,
    parameter int BLINK_FRAMES = 64
)(
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);

    localparam int SLOT_W  = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int CODES_W = CODE_W * NUM_DIGITS;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  DEAD_LIMIT = SLOT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    // Scan position
    logic [SLOT_W-1:0]  slot_cnt;
    logic [IDX_W-1:0]   dig_idx;
    logic [FRAME_W-1:0] frame_cnt;
    blink_phase_t       blink_phase;

    // Double-buffered display data
    logic [CODES_W-1:0]    stage_codes;
    logic [NUM_DIGITS-1:0] stage_blank;
    logic [NUM_DIGITS-1:0] stage_blink;
    logic [NUM_DIGITS-1:0] stage_dp;
    logic                  pending;

    logic [CODES_W-1:0]    act_codes;
    logic [NUM_DIGITS-1:0] act_blank;
    logic [NUM_DIGITS-1:0] act_blink;
    logic [NUM_DIGITS-1:0] act_dp;

    // Registered outputs
    logic [SEG_W-1:0]      seg_out_r;
    logic [NUM_DIGITS-1:0] dig_sel_r;
    logic                  frame_done_r;

    // Combinational helpers
    logic                  slot_last;
    logic                  frame_end;
    logic                  in_dead;
    logic [CODE_W-1:0]     cur_code;
    logic                  cur_dp;
    logic                  cur_dark;
    logic [SEG_W-1:0]      cur_pattern;
    logic [NUM_DIGITS-1:0] cur_onehot;

    assign slot_last = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_last && (dig_idx == IDX_LAST);
    assign in_dead   = (slot_cnt < DEAD_LIMIT);

    // Active entry of the digit currently being scanned
    assign cur_code   = act_codes[{dig_idx, 2'b00} +: CODE_W];
    assign cur_dp     = act_dp[dig_idx];
    assign cur_onehot = NUM_DIGITS'(1) << dig_idx;

    // A blanked or blinked-off digit keeps its select line so the scan duty
    // cycle stays uniform; only the segments go dark.
    assign cur_dark = act_blank[dig_idx] ||
                      (act_blink[dig_idx] && (blink_phase == BLINK_OFF));

    seg_glyph_decode u_decode (
        .code    (cur_code),
        .dp      (cur_dp),
        .pattern (cur_pattern)
    );

    // Slot counter and digit index: the slot counter runs 0..SCAN_DIV-1 and
    // each wrap advances the digit index, itself wrapping at NUM_DIGITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            if (dig_idx == IDX_LAST) begin
                dig_idx <= '0;
            end else begin
                dig_idx <= dig_idx + 1'b1;
            end
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Blink timing: count whole frames and flip the blink phase every
    // BLINK_FRAMES frames. Because the flip lands on the frame-end edge, a
    // phase always covers complete frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= BLINK_ON;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= (blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Staging and commit. A load lands in staging and marks it pending; the
    // frame-end edge moves staging into the active set. A load on the
    // frame-end cycle itself is forwarded straight into the active set, since
    // staging would otherwise only update on that same edge and the data
    // would miss the next frame. Reset clears both sets to "all blank".
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_codes <= '0;
            stage_blank <= '1;
            stage_blink <= '0;
            stage_dp    <= '0;
            pending     <= 1'b0;
            act_codes   <= '0;
            act_blank   <= '1;
            act_blink   <= '0;
            act_dp      <= '0;
        end else begin
            if (bus.load) begin
                stage_codes <= bus.codes_in;
                stage_blank <= bus.blank_in;
                stage_blink <= bus.blink_in;
                stage_dp    <= bus.dp_in;
            end

            if (frame_end) begin
                pending <= 1'b0;
                if (bus.load) begin
                    act_codes <= bus.codes_in;
                    act_blank <= bus.blank_in;
                    act_blink <= bus.blink_in;
                    act_dp    <= bus.dp_in;
                end else if (pending) begin
                    act_codes <= stage_codes;
                    act_blank <= stage_blank;
                    act_blink <= stage_blink;
                    act_dp    <= stage_dp;
                end
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    // Output registers, one cycle behind the scan counters. During the dead
    // window both the digit enables and the segments are forced off.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out_r    <= '0;
            dig_sel_r    <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= frame_end;
            if (in_dead) begin
                dig_sel_r <= '0;
                seg_out_r <= '0;
            end else begin
                dig_sel_r <= cur_onehot;
                seg_out_r <= cur_dark ? '0 : cur_pattern;
            end
        end
    end

    assign bus.seg_out    = seg_out_r;
    assign bus.dig_sel    = dig_sel_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed bench for seg_scan_driver with a 4-digit, 10-cycle-slot,
// 2-dead-cycle, 2-frame-blink configuration (40-cycle frames). Position
// 'pos' counts falling edges since the last frame start (the falling edge on
// which frame_done is high, or the one right after reset); digit k is dark at
// pos 10k+1..10k+2 and selected at pos 10k+3..10k+10.
// ----------------------------------------------------------------------------
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int ND = 4;
    localparam int SD = 10;
    localparam int DC = 2;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .DEAD_CYCLES  (DC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int assertCount = 0;
    int failCount   = 0;
    int pos         = 0;
    int frameNum    = 0;

    // Expected full pattern of each code with dp off
    logic [7:0] sweepTable [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h0A, 8'hB6, 8'h6E, 8'h1C,
        8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to a falling-edge position within the current frame
    task automatic stepTo(input int p);
        while (pos < p) begin
            @(negedge clk);
            pos++;
        end
    endtask

    // Wait (bounded) for the frame_done pulse; it must arrive 40 cycles
    // after the previous frame start
    task automatic waitFrame();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (pos != 0 && bus.frame_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                pos++;
            end
        end
        checkOutput("frame_seen", 32'(seen), 32'd1);
        checkOutput("frame_period", pos, ND * SD);
        pos = 0;
        frameNum++;
    endtask

    // One-cycle load strobe with the given display data
    task automatic applyStimulus(input logic [15:0] codes, input logic [3:0] blank,
                                 input logic [3:0] blink, input logic [3:0] dp);
        bus.codes_in = codes;
        bus.blank_in = blank;
        bus.blink_in = blink;
        bus.dp_in    = dp;
        bus.load     = 1'b1;
        @(negedge clk);
        pos++;
        bus.load     = 1'b0;
    endtask

    // Mid-slot check of digit k: its select line and its segments
    task automatic checkDigit(input string tag, input int k, input logic [7:0] seg);
        stepTo(10 * k + 5);
        checkOutput({tag, "_sel"}, 32'(bus.dig_sel), 32'(1 << k));
        checkOutput({tag, "_seg"}, 32'(bus.seg_out), 32'(seg));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_seg"}, 32'(bus.seg_out), 32'd0);
        checkOutput({tag, "_sel"}, 32'(bus.dig_sel), 32'd0);
        checkOutput({tag, "_fd"}, 32'(bus.frame_done), 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] expSeg;

        rst          = 1'b1;
        bus.codes_in = '0;
        bus.blank_in = '0;
        bus.blink_in = '0;
        bus.dp_in    = '0;
        bus.load     = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst      = 1'b0;
        pos      = 0;
        frameNum = 0;

        // Frame 0: dark scan walk with dead windows
        stepTo(1);  checkOutput("f0_dead0", 32'(bus.dig_sel), 32'd0);
        stepTo(2);  checkOutput("f0_dead1", 32'(bus.dig_sel), 32'd0);
        stepTo(3);  checkOutput("f0_d0_first", 32'(bus.dig_sel), 32'b0001);
        checkOutput("f0_d0_dark", 32'(bus.seg_out), 32'd0);
        stepTo(10); checkOutput("f0_d0_last", 32'(bus.dig_sel), 32'b0001);
        stepTo(11); checkOutput("f0_d1_dead", 32'(bus.dig_sel), 32'd0);
        stepTo(13); checkOutput("f0_d1", 32'(bus.dig_sel), 32'b0010);
        stepTo(23); checkOutput("f0_d2", 32'(bus.dig_sel), 32'b0100);
        stepTo(33); checkOutput("f0_d3", 32'(bus.dig_sel), 32'b1000);
        checkOutput("f0_d3_dark", 32'(bus.seg_out), 32'd0);
        stepTo(39); checkOutput("f0_fd_low", 32'(bus.frame_done), 32'd0);
        waitFrame();
        checkOutput("f0_end_sel", 32'(bus.dig_sel), 32'b1000);
        stepTo(1);  checkOutput("f1_fd_pulse", 32'(bus.frame_done), 32'd0);
        checkOutput("f1_dead", 32'(bus.dig_sel), 32'd0);
        waitFrame();

        // Frame 2: mid-frame load must not disturb the current frame
        stepTo(10);
        applyStimulus(16'hFA50, 4'b0000, 4'b0000, 4'b0100);
        checkDigit("f2_d1", 1, 8'h00);
        checkDigit("f2_d2", 2, 8'h00);
        waitFrame();

        // Frame 3: committed data
        checkDigit("f3_d0", 0, 8'hFC);
        checkDigit("f3_d1", 1, 8'hB6);
        checkDigit("f3_d2", 2, 8'hEF);
        checkDigit("f3_d3", 3, 8'h8E);

        // Blink digit 0 showing '3'; phase flips every two frames
        stepTo(36);
        applyStimulus(16'hFA53, 4'b0000, 4'b0001, 4'b0100);
        for (int f = 0; f < 4; f++) begin
            waitFrame();
            expSeg = (((frameNum / BF) % 2) == 0) ? 8'hF2 : 8'h00;
            checkDigit("blink_d0", 0, expSeg);
            checkDigit("blink_d1", 1, 8'hB6);
        end

        // Frame 8: two loads in one frame, last one wins
        waitFrame();
        stepTo(5);
        applyStimulus(16'hFA51, 4'b0000, 4'b0000, 4'b0100);
        stepTo(15);
        applyStimulus(16'hFA52, 4'b0000, 4'b0000, 4'b0100);
        waitFrame();
        checkDigit("lastwins_d0", 0, 8'hDA);
        checkDigit("lastwins_d2", 2, 8'hEF);

        // Load on the exact frame-end cycle is bypassed into the next frame
        stepTo(39);
        applyStimulus(16'hFA56, 4'b0000, 4'b0000, 4'b0100);
        waitFrame();
        checkDigit("bypass_d0", 0, 8'h6E);

        // Reset at slot 5 of digit 2 with a load still pending
        stepTo(8);
        applyStimulus(16'hFA58, 4'b0000, 4'b0000, 4'b0000);
        stepTo(25);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        rst      = 1'b0;
        pos      = 0;
        frameNum = 0;
        checkDigit("postrst_d0", 0, 8'h00);
        checkDigit("postrst_d1", 1, 8'h00);
        waitFrame();
        checkDigit("postrst_f1_d0", 0, 8'h00);

        // Sweep every code on digit 0
        for (int c = 0; c < 16; c++) begin
            stepTo(39);
            applyStimulus(16'(c), 4'b0000, 4'b0000, 4'b0000);
            waitFrame();
            checkDigit($sformatf("sweep_%0h", c), 0, sweepTable[c]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
